// File: rtl/skewed_sync_int_mc_if.sv
// rtl/skewed_sync_int_mc_if.sv - control, data and status bundle for skewed_sync_int_mc (drop_cnt only with SKEW_SYNC_DROP_CNT_EN)
interface skewed_sync_int_mc_if #(
  parameter int CH    = 2,
  parameter int BWIN  = 2,
  parameter int BWOUT = 3,
  parameter int BWSEL = 2
);
  logic                  en;
  logic                  flush;
  logic                  ovf_clr;
  logic [CH*BWIN-1:0]    in0;
  logic [BWSEL-1:0]      in1;
  logic [CH*BWOUT-1:0]   out0;
  logic [BWSEL-1:0]      out1;
  logic [CH-1:0]         empty;
  logic [CH-1:0]         ovf;
`ifdef SKEW_SYNC_DROP_CNT_EN
  logic [CH*16-1:0]      drop_cnt;

  modport master (output en, flush, ovf_clr, in0, in1,
                  input  out0, out1, empty, ovf, drop_cnt);
  modport slave  (input  en, flush, ovf_clr, in0, in1,
                  output out0, out1, empty, ovf, drop_cnt);
`else
  modport master (output en, flush, ovf_clr, in0, in1,
                  input  out0, out1, empty, ovf);
  modport slave  (input  en, flush, ovf_clr, in0, in1,
                  output out0, out1, empty, ovf);
`endif
endinterface

// File: rtl/skewed_sync_int_mc.sv
// rtl/skewed_sync_int_mc.sv - multi-channel skewed synchroniser for integer unary streams; optional drop counters via SKEW_SYNC_DROP_CNT_EN
module skewed_sync_int_mc #(
  parameter int CH    = 2,
  parameter int DEP   = 4,
  parameter int BWIN  = 2,
  parameter int BWOUT = 3,
  parameter int BWSEL = 2,
  parameter int MODE  = 0
) (
  input logic              clk,
  input logic              rst_n,
  skewed_sync_int_mc_if.slave bus
);
  // Arithmetic width wide enough for cnt+in0 and for the in1 weight
  localparam int AW = (DEP + 1 > BWSEL) ? DEP + 1 : BWSEL;
  localparam logic [AW-1:0] CAP  = AW'((1 << BWOUT) - 1);
  localparam logic [AW-1:0] MAXC = AW'((1 << DEP) - 1);

  logic [BWSEL-1:0] out1_q;

  // Delay the release weight by one cycle so it lines up with out0
  always_ff @(posedge clk) begin
    if (!rst_n)      out1_q <= '0;
    else if (bus.en) out1_q <= bus.in1;
    else             out1_q <= '0;
  end

  assign bus.out1 = out1_q;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [DEP-1:0]   cnt;
    logic [DEP-1:0]   cnt_nxt;
    logic [BWOUT-1:0] out0_q;
    logic             ovf_q;
    logic             ovf_set;
    logic [AW-1:0]    avail;
    logic [AW-1:0]    rel;
    logic [AW-1:0]    rem;
`ifdef SKEW_SYNC_DROP_CNT_EN
    logic [AW-1:0]    drop;
    logic [15:0]      dcnt;
    logic [15:0]      dcnt_base;
    logic [16:0]      dcnt_sum;
    logic [15:0]      dcnt_nxt;
`endif

    // Release amount and saturating remainder for this channel
    always_comb begin
      avail = AW'(cnt) + AW'(bus.in0[c*BWIN +: BWIN]);
      rel   = '0;
      if (bus.flush || (bus.in1 != '0)) begin
        rel = (avail < CAP) ? avail : CAP;
        if (!bus.flush && (MODE == 1) && (AW'(bus.in1) < rel)) rel = AW'(bus.in1);
      end
      rem     = avail - rel;
      ovf_set = (rem > MAXC);
      cnt_nxt = ovf_set ? DEP'(MAXC) : DEP'(rem);
`ifdef SKEW_SYNC_DROP_CNT_EN
      drop      = ovf_set ? (rem - MAXC) : '0;
      dcnt_base = bus.ovf_clr ? 16'd0 : dcnt;
      dcnt_sum  = {1'b0, dcnt_base} + 17'(drop);
      dcnt_nxt  = dcnt_sum[16] ? 16'hFFFF : dcnt_sum[15:0];
`endif
    end

    // Buffer count, registered release and sticky overflow; en=0 freezes state
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt    <= '0;
        out0_q <= '0;
        ovf_q  <= 1'b0;
      end else if (bus.en) begin
        cnt    <= cnt_nxt;
        out0_q <= rel[BWOUT-1:0];
        ovf_q  <= (ovf_q && !bus.ovf_clr) || ovf_set;
      end else begin
        out0_q <= '0;
      end
    end

`ifdef SKEW_SYNC_DROP_CNT_EN
    // Saturating count of units discarded since reset or last ovf_clr
    always_ff @(posedge clk) begin
      if (!rst_n)      dcnt <= '0;
      else if (bus.en) dcnt <= dcnt_nxt;
    end

    assign bus.drop_cnt[c*16 +: 16] = dcnt;
`endif

    assign bus.out0[c*BWOUT +: BWOUT] = out0_q;
    assign bus.empty[c]               = (cnt == '0);
    assign bus.ovf[c]                 = ovf_q;
  end
endmodule

// File: tb/tb_skewed_sync_int_mc.sv
// tb/tb_skewed_sync_int_mc.sv - self-checking bench for skewed_sync_int_mc in both release modes
module tb_skewed_sync_int_mc;
  localparam int CH    = 2;
  localparam int DEP   = 4;
  localparam int BWIN  = 2;
  localparam int BWOUT = 3;
  localparam int BWSEL = 2;
  localparam int CAP   = (1 << BWOUT) - 1;
  localparam int MAXC  = (1 << DEP) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state per mode (index 0 = MODE 0, 1 = MODE 1) and channel
  int m_cnt  [2][CH];
  int m_ovf  [2][CH];
  int m_dc   [2][CH];
  int m_out0 [2][CH];
  int m_out1 [2];

  skewed_sync_int_mc_if #(.CH(CH), .BWIN(BWIN), .BWOUT(BWOUT), .BWSEL(BWSEL)) bus0 ();
  skewed_sync_int_mc_if #(.CH(CH), .BWIN(BWIN), .BWOUT(BWOUT), .BWSEL(BWSEL)) bus1 ();

  assign bus1.en      = bus0.en;
  assign bus1.flush   = bus0.flush;
  assign bus1.ovf_clr = bus0.ovf_clr;
  assign bus1.in0     = bus0.in0;
  assign bus1.in1     = bus0.in1;

  skewed_sync_int_mc #(.CH(CH), .DEP(DEP), .BWIN(BWIN), .BWOUT(BWOUT), .BWSEL(BWSEL), .MODE(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  skewed_sync_int_mc #(.CH(CH), .DEP(DEP), .BWIN(BWIN), .BWOUT(BWOUT), .BWSEL(BWSEL), .MODE(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_update();
    int avail, rel, rem, drop, base, w;
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < CH; c++) begin
        if (!rst_n) begin
          m_cnt[m][c] = 0; m_ovf[m][c] = 0; m_dc[m][c] = 0; m_out0[m][c] = 0;
        end else if (!bus0.en) begin
          m_out0[m][c] = 0;
        end else begin
          w     = int'(bus0.in1);
          avail = m_cnt[m][c] + int'(bus0.in0[c*BWIN +: BWIN]);
          if (bus0.flush)  rel = imin(avail, CAP);
          else if (w == 0) rel = 0;
          else if (m == 0) rel = imin(avail, CAP);
          else             rel = imin(imin(avail, CAP), w);
          rem  = avail - rel;
          drop = (rem > MAXC) ? rem - MAXC : 0;
          m_cnt[m][c]  = rem - drop;
          m_out0[m][c] = rel;
          m_ovf[m][c]  = ((m_ovf[m][c] != 0 && !bus0.ovf_clr) || drop > 0) ? 1 : 0;
          base         = bus0.ovf_clr ? 0 : m_dc[m][c];
          m_dc[m][c]   = imin(base + drop, 65535);
        end
      end
      m_out1[m] = (rst_n && bus0.en) ? int'(bus0.in1) : 0;
    end
  endfunction

  function automatic logic [CH*BWOUT-1:0] exp_out0(input int m);
    logic [CH*BWOUT-1:0] v;
    for (int c = 0; c < CH; c++) v[c*BWOUT +: BWOUT] = BWOUT'(m_out0[m][c]);
    return v;
  endfunction

  function automatic logic [CH-1:0] exp_empty(input int m);
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = (m_cnt[m][c] == 0);
    return v;
  endfunction

  function automatic logic [CH-1:0] exp_ovf(input int m);
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = (m_ovf[m][c] != 0);
    return v;
  endfunction

  function automatic logic [CH*16-1:0] exp_dc(input int m);
    logic [CH*16-1:0] v;
    for (int c = 0; c < CH; c++) v[c*16 +: 16] = 16'(m_dc[m][c]);
    return v;
  endfunction

  task automatic set_in(input logic en, input logic flush, input logic clr,
                        input int a0, input int a1, input int w);
    bus0.en      = en;
    bus0.flush   = flush;
    bus0.ovf_clr = clr;
    bus0.in0     = {BWIN'(a1), BWIN'(a0)};
    bus0.in1     = BWSEL'(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 0, 0, 0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b1, 1'b0, 3, 3, 3);
    step();
    do_reset();
    n_checks++; if (bus0.out0 !== '0) begin n_errors++; $display("FAIL reset_out0 got %h want 0", bus0.out0); end
    n_checks++; if (bus0.out1 !== '0) begin n_errors++; $display("FAIL reset_out1 got %h want 0", bus0.out1); end
    n_checks++; if (bus0.empty !== 2'b11) begin n_errors++; $display("FAIL reset_empty got %b want 11", bus0.empty); end
    n_checks++; if (bus0.ovf !== 2'b00) begin n_errors++; $display("FAIL reset_ovf got %b want 00", bus0.ovf); end
`ifdef SKEW_SYNC_DROP_CNT_EN
    n_checks++; if (bus0.drop_cnt !== '0) begin n_errors++; $display("FAIL reset_drop_cnt got %h want 0", bus0.drop_cnt); end
`endif
  endtask

  task automatic test_accumulate();
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1, 3, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (bus0.out0 !== '0) begin n_errors++; $display("FAIL acc_hold%0d out0 got %h want 0", i, bus0.out0); end
    end
    set_in(1'b1, 1'b0, 1'b0, 0, 0, 1);
    step();
    n_checks++; if (bus0.out0 !== {3'd7, 3'd3}) begin n_errors++; $display("FAIL acc_release out0 got %h want %h", bus0.out0, {3'd7, 3'd3}); end
    n_checks++; if (bus0.out1 !== 2'd1) begin n_errors++; $display("FAIL acc_release out1 got %0d want 1", bus0.out1); end
    n_checks++; if (bus0.empty !== 2'b01) begin n_errors++; $display("FAIL acc_release empty got %b want 01", bus0.empty); end
    set_in(1'b1, 1'b1, 1'b0, 0, 0, 0);
    step();
    n_checks++; if (bus0.out0 !== {3'd2, 3'd0}) begin n_errors++; $display("FAIL acc_rest out0 got %h want %h", bus0.out0, {3'd2, 3'd0}); end
    n_checks++; if (bus0.empty !== 2'b11) begin n_errors++; $display("FAIL acc_rest empty got %b want 11", bus0.empty); end
  endtask

  task automatic test_overflow();
    logic [5:0] want [3];
    want[0] = {3'd0, 3'd7}; want[1] = {3'd0, 3'd7}; want[2] = {3'd0, 3'd1};
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 3, 0, 0);
    repeat (5) step();
    n_checks++; if (bus0.ovf !== 2'b00) begin n_errors++; $display("FAIL ovf_full ovf got %b want 00", bus0.ovf); end
    n_checks++; if (bus0.empty !== 2'b10) begin n_errors++; $display("FAIL ovf_full empty got %b want 10", bus0.empty); end
    step();
    n_checks++; if (bus0.ovf !== 2'b01) begin n_errors++; $display("FAIL ovf_set ovf got %b want 01", bus0.ovf); end
    set_in(1'b1, 1'b0, 1'b1, 0, 0, 0);
    step();
    n_checks++; if (bus0.ovf !== 2'b00) begin n_errors++; $display("FAIL ovf_clr ovf got %b want 00", bus0.ovf); end
    set_in(1'b1, 1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (bus0.out0 !== want[i]) begin n_errors++; $display("FAIL ovf_drain%0d out0 got %h want %h", i, bus0.out0, want[i]); end
    end
  endtask

  task automatic test_mode1();
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 3, 0, 0);
    repeat (2) step();
    set_in(1'b1, 1'b0, 1'b0, 0, 0, 2);
    step();
    n_checks++; if (bus1.out0 !== {3'd0, 3'd2}) begin n_errors++; $display("FAIL m1_w2 out0 got %h want %h", bus1.out0, {3'd0, 3'd2}); end
    n_checks++; if (bus1.out1 !== 2'd2) begin n_errors++; $display("FAIL m1_w2 out1 got %0d want 2", bus1.out1); end
    n_checks++; if (bus0.out0 !== {3'd0, 3'd6}) begin n_errors++; $display("FAIL m0_w2 out0 got %h want %h", bus0.out0, {3'd0, 3'd6}); end
    set_in(1'b1, 1'b0, 1'b0, 0, 0, 3);
    step();
    n_checks++; if (bus1.out0 !== {3'd0, 3'd3}) begin n_errors++; $display("FAIL m1_w3 out0 got %h want %h", bus1.out0, {3'd0, 3'd3}); end
    n_checks++; if (bus1.out1 !== 2'd3) begin n_errors++; $display("FAIL m1_w3 out1 got %0d want 3", bus1.out1); end
    n_checks++; if (bus0.out0 !== '0) begin n_errors++; $display("FAIL m0_w3 out0 got %h want 0", bus0.out0); end
    set_in(1'b1, 1'b1, 1'b0, 0, 0, 0);
    step();
    n_checks++; if (bus1.out0 !== {3'd0, 3'd1}) begin n_errors++; $display("FAIL m1_rest out0 got %h want %h", bus1.out0, {3'd0, 3'd1}); end
    n_checks++; if (bus1.out1 !== 2'd0) begin n_errors++; $display("FAIL m1_rest out1 got %0d want 0", bus1.out1); end
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 3, 0, 0);
    repeat (3) step();
    set_in(1'b1, 1'b0, 1'b0, 1, 0, 0);
    step();
    set_in(1'b1, 1'b1, 1'b0, 0, 0, 0);
    step();
    n_checks++; if (bus0.out0 !== {3'd0, 3'd7}) begin n_errors++; $display("FAIL flush1 out0 got %h want %h", bus0.out0, {3'd0, 3'd7}); end
    n_checks++; if (bus1.out0 !== {3'd0, 3'd7}) begin n_errors++; $display("FAIL flush1_m1 out0 got %h want %h", bus1.out0, {3'd0, 3'd7}); end
    step();
    n_checks++; if (bus0.out0 !== {3'd0, 3'd3}) begin n_errors++; $display("FAIL flush2 out0 got %h want %h", bus0.out0, {3'd0, 3'd3}); end
    n_checks++; if (bus0.empty !== 2'b11) begin n_errors++; $display("FAIL flush2 empty got %b want 11", bus0.empty); end
  endtask

  task automatic test_enable_reset();
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 2, 1, 0);
    repeat (2) step();
    set_in(1'b0, 1'b1, 1'b1, 3, 3, 3);
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (bus0.out0 !== '0) begin n_errors++; $display("FAIL en0_%0d out0 got %h want 0", i, bus0.out0); end
      n_checks++; if (bus0.out1 !== '0) begin n_errors++; $display("FAIL en0_%0d out1 got %h want 0", i, bus0.out1); end
    end
    set_in(1'b1, 1'b1, 1'b0, 0, 0, 0);
    step();
    n_checks++; if (bus0.out0 !== {3'd2, 3'd4}) begin n_errors++; $display("FAIL en_resume out0 got %h want %h", bus0.out0, {3'd2, 3'd4}); end
    set_in(1'b1, 1'b0, 1'b0, 1, 3, 0);
    repeat (6) step();
    n_checks++; if (bus0.ovf !== 2'b10) begin n_errors++; $display("FAIL pre_rst ovf got %b want 10", bus0.ovf); end
    set_in(1'b1, 1'b0, 1'b0, 0, 0, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++; if (bus0.out0 !== '0) begin n_errors++; $display("FAIL mid_rst out0 got %h want 0", bus0.out0); end
    n_checks++; if (bus0.out1 !== '0) begin n_errors++; $display("FAIL mid_rst out1 got %h want 0", bus0.out1); end
    n_checks++; if (bus0.empty !== 2'b11) begin n_errors++; $display("FAIL mid_rst empty got %b want 11", bus0.empty); end
    n_checks++; if (bus0.ovf !== 2'b00) begin n_errors++; $display("FAIL mid_rst ovf got %b want 00", bus0.ovf); end
    set_in(1'b1, 1'b1, 1'b0, 0, 0, 0);
    step();
    n_checks++; if (bus0.out0 !== '0) begin n_errors++; $display("FAIL post_rst out0 got %h want 0", bus0.out0); end
  endtask

`ifdef SKEW_SYNC_DROP_CNT_EN
  task automatic test_drop_cnt();
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 3, 0, 0);
    repeat (6) step();
    set_in(1'b1, 1'b0, 1'b0, 1, 0, 0);
    step();
    set_in(1'b1, 1'b0, 1'b0, 2, 0, 0);
    step();
    n_checks++; if (bus0.drop_cnt[15:0] !== 16'd6) begin n_errors++; $display("FAIL dcnt_sum got %0d want 6", bus0.drop_cnt[15:0]); end
    set_in(1'b1, 1'b0, 1'b1, 2, 0, 0);
    step();
    n_checks++; if (bus0.drop_cnt[15:0] !== 16'd2) begin n_errors++; $display("FAIL dcnt_clr got %0d want 2", bus0.drop_cnt[15:0]); end
    n_checks++; if (bus0.ovf[0] !== 1'b1) begin n_errors++; $display("FAIL dcnt_clr ovf got %b want 1", bus0.ovf[0]); end
  endtask
`endif

  task automatic test_random();
    logic [CH*BWOUT-1:0] o0 [2];
    logic [BWSEL-1:0]    o1 [2];
    logic [CH-1:0]       oe [2];
    logic [CH-1:0]       ov [2];
`ifdef SKEW_SYNC_DROP_CNT_EN
    logic [CH*16-1:0]    od [2];
`endif
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst_n        = ($urandom_range(0, 99) != 0);
      bus0.en      = ($urandom_range(0, 9) != 0);
      bus0.flush   = ($urandom_range(0, 9) == 0);
      bus0.ovf_clr = ($urandom_range(0, 19) == 0);
      for (int c = 0; c < CH; c++) bus0.in0[c*BWIN +: BWIN] = BWIN'($urandom_range(0, (1 << BWIN) - 1));
      bus0.in1     = ($urandom_range(0, 2) == 0) ? '0 : BWSEL'($urandom_range(0, (1 << BWSEL) - 1));
      step();
      o0[0] = bus0.out0; o1[0] = bus0.out1; oe[0] = bus0.empty; ov[0] = bus0.ovf;
      o0[1] = bus1.out0; o1[1] = bus1.out1; oe[1] = bus1.empty; ov[1] = bus1.ovf;
`ifdef SKEW_SYNC_DROP_CNT_EN
      od[0] = bus0.drop_cnt; od[1] = bus1.drop_cnt;
`endif
      for (int m = 0; m < 2; m++) begin
        n_checks++; if (o0[m] !== exp_out0(m)) begin n_errors++; $display("FAIL rnd_out0 mode%0d cyc%0d got %h want %h", m, cyc, o0[m], exp_out0(m)); end
        n_checks++; if (o1[m] !== BWSEL'(m_out1[m])) begin n_errors++; $display("FAIL rnd_out1 mode%0d cyc%0d got %h want %0d", m, cyc, o1[m], m_out1[m]); end
        n_checks++; if (oe[m] !== exp_empty(m)) begin n_errors++; $display("FAIL rnd_empty mode%0d cyc%0d got %b want %b", m, cyc, oe[m], exp_empty(m)); end
        n_checks++; if (ov[m] !== exp_ovf(m)) begin n_errors++; $display("FAIL rnd_ovf mode%0d cyc%0d got %b want %b", m, cyc, ov[m], exp_ovf(m)); end
`ifdef SKEW_SYNC_DROP_CNT_EN
        n_checks++; if (od[m] !== exp_dc(m)) begin n_errors++; $display("FAIL rnd_drop_cnt mode%0d cyc%0d got %h want %h", m, cyc, od[m], exp_dc(m)); end
`endif
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    set_in(1'b1, 1'b0, 1'b0, 0, 0, 0);
    test_reset();
    test_accumulate();
    test_overflow();
    test_mode1();
    test_flush();
    test_enable_reset();
`ifdef SKEW_SYNC_DROP_CNT_EN
    test_drop_cnt();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/skewed_sync_int_mc.md
Name: skewed_sync_int_mc

Overview:
Multi-channel, parametrised skewed synchroniser for integer-valued unary streams. Each channel accumulates incoming integer unit counts (in0) into a saturating buffer. A shared integer release stream (in1) drains each buffer, optionally capped by the in1 weight. Adds registered outputs, flush, empty status, sticky overflow and a configurable release policy; used in front of unary arithmetic to align CH operand streams to one reference stream.

Parameters:
CH, 2, number of independent channels sharing in1
DEP, 4, buffer counter width per channel (max 2^DEP-1 units); BWIN <= DEP required
BWIN, 2, per-channel in0 width (units per cycle)
BWOUT, 3, per-channel out0 width; release cap = 2^BWOUT-1; BWOUT <= DEP+1 required
BWSEL, 2, in1/out1 width (release weight)
MODE, 0, 0 = release-all when in1!=0; 1 = release at most in1 units

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
en  input  1  advance enable; 0 freezes all state
flush  input  1  force release regardless of in1/MODE
in0  input  CH*BWIN  per-channel incoming units, channel c at [c*BWIN +: BWIN]
in1  input  BWSEL  release weight (0 = no release)
ovf_clr  input  1  clear sticky overflow flags
out0  output  CH*BWOUT  per-channel released units, registered
out1  output  BWSEL  in1 delayed one cycle (kept aligned with out0)
empty  output  CH  buffer count == 0, from registered count
ovf  output  CH  sticky: channel dropped units since last clear
drop_cnt  output  CH*16  per-channel dropped-unit count (only with macro)

Behaviour:
- One clock: clk. Reset is synchronous and active-low (rst_n), sampled on the clk rising edge.
- Reset: cnt=0, out0=0, out1=0, ovf=0, empty=all ones, drop_cnt=0. Reset mid-operation discards buffered units with no output.
- Per channel, each cycle with en=1:
  - avail = cnt + in0 (DEP+1 bits).
  - cap = 2^BWOUT-1.
  - Release amount rel:
    - flush=1: rel = min(avail, cap).
    - else if in1==0: rel = 0.
    - else MODE0: rel = min(avail, cap).
    - else MODE1: rel = min(avail, cap, in1).
  - rem = avail - rel.
    - If rem > 2^DEP-1: cnt <= 2^DEP-1, drop = rem-(2^DEP-1), ovf set.
    - Otherwise cnt <= rem, drop = 0.
  - out0 <= rel; out1 <= in1.
- Latency: out0/out1 appear exactly 1 cycle after the inputs that produced them.
- en=0: cnt, ovf and drop_cnt hold; out0 <= 0, out1 <= 0; inputs ignored.
- ovf_clr with a new overflow in the same cycle: set wins (ovf stays 1).
- Units are conserved: sum of in0 = sum of out0 + final cnt + dropped units.
- empty reflects the post-update cnt (registered).

Optional Feature:
SKEW_SYNC_DROP_CNT_EN:
- Defined: per-channel 16-bit counter adds drop each cycle, saturating at 0xFFFF; cleared by reset and by ovf_clr (ovf_clr takes effect before the add in the same cycle); drop_cnt port exists.
- Undefined: no counter logic and no drop_cnt port; ovf behaviour unchanged.

Test Plan:
1. Defaults, in0={ch0=1,ch1=3}, in1=0 for 3 cycles, then in0=0, in1=1 -> out0 0 during accumulation; cycle after release out0 ch0=3, ch1=7 (cap); ch1 cnt=2, empty={ch1=0, ch0=1}.
2. ch0 in0=3, in1=0 for 6 cycles -> cnt=15 after 5 cycles; 6th: cnt stays 15, ovf[0]=1 (drop 3); pulse ovf_clr -> ovf[0]=0.
3. MODE=1, ch0 cnt=6, in0=0: in1=2 -> out0=2, cnt=4; then in1=3 -> out0=3, cnt=1; out1 tracks in1 delayed 1 cycle.
4. ch0 cnt=10, in1=0, flush=1 for 2 cycles -> out0=7 then 3; cnt=0, empty[0]=1.
5. en=0 for 4 cycles with nonzero in0/in1 -> cnt unchanged, out0=0; then rst_n=0 one cycle -> all cnt=0, ovf=0, outputs 0.
6. Macro defined, three overflow cycles dropping 3,1,2 units -> drop_cnt ch0=6; ovf_clr together with a drop of 2 -> drop_cnt=2, ovf=1.
